// File: rtl/dtof_hist_builder_pp.sv
// rtl/dtof_hist_builder_pp.sv - ping-pong per-pixel dToF histogram builder
// Saturating RMW accumulation into the active bank; the finished bank is served on rd_addr/rd_data.
module dtof_hist_builder_pp #(
    parameter int NB        = 4,
    parameter int BIN_W     = 8,
    parameter int DATA_NUM  = 3,
    parameter int PIXEL_NUM = 2,
    parameter int ACQ_NUM   = 2,
    parameter int PW        = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             wr_en,
    input  logic [NB-1:0]    addr,
    output logic             ready,
    input  logic [PW+NB-1:0] rd_addr,
    output logic [BIN_W-1:0] rd_data,
    output logic [PW-1:0]    pixel_idx,
    output logic             his_num,
    output logic             acq_done,
    output logic             sat_flag,
    output logic             drop_flag
);
    localparam int AW    = PW + NB;
    localparam int DEPTH = 2 ** AW;
    localparam int IW    = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
    localparam int QW    = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
    localparam logic [AW-1:0]    CLR_LAST = AW'(PIXEL_NUM * (2 ** NB) - 1);
    localparam logic [IW-1:0]    IN_LAST  = IW'(DATA_NUM - 1);
    localparam logic [PW-1:0]    PIX_LAST = PW'(PIXEL_NUM - 1);
    localparam logic [QW-1:0]    ACQ_LAST = QW'(ACQ_NUM - 1);
    localparam logic [BIN_W-1:0] BIN_MAX  = '1;

    typedef enum logic {S_CLEAR, S_ACCUM} state_t;
    state_t r_state, w_state_nxt;

    logic [BIN_W-1:0] r_bank0 [DEPTH];
    logic [BIN_W-1:0] r_bank1 [DEPTH];

    logic [AW-1:0]    r_clr_cnt;
    logic             r_clr_both;
    logic [IW-1:0]    r_in_cnt;
    logic [PW-1:0]    r_pix;
    logic [QW-1:0]    r_acq;
    logic             r_his;
    logic             r_wb_valid;
    logic [AW-1:0]    r_wb_addr;
    logic             r_wb_bank;
    logic [BIN_W-1:0] r_wb_data;
    logic             r_sat_int;
    logic             r_sat_flag;
    logic             r_drop;
    logic             r_acq_done;
    logic [BIN_W-1:0] r_rd_data;

    logic             w_clear, w_accept, w_last_in, w_last_pix, w_swap, w_clr_last;
    logic             w_wb_sat, w_fwd;
    logic [AW-1:0]    w_acc_addr;
    logic [BIN_W-1:0] w_inc, w_rd_acc;

    always_comb begin
        w_clear    = (r_state == S_CLEAR);
        w_accept   = wr_en & ~w_clear;
        w_acc_addr = {r_pix, addr};
        w_last_in  = (r_in_cnt == IN_LAST);
        w_last_pix = (r_pix == PIX_LAST);
        w_swap     = w_accept & w_last_in & w_last_pix & (r_acq == ACQ_LAST);
        w_clr_last = w_clear & (r_clr_cnt == CLR_LAST);
        w_inc      = (r_wb_data == BIN_MAX) ? r_wb_data : r_wb_data + BIN_W'(1);
        w_wb_sat   = r_wb_valid & (w_inc == BIN_MAX);
        // The bin being written this cycle is stale in RAM; take the in-flight value instead.
        w_fwd      = r_wb_valid & (r_wb_addr == w_acc_addr) & (r_wb_bank == r_his);
        w_rd_acc   = r_his ? r_bank1[w_acc_addr] : r_bank0[w_acc_addr];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (w_clr_last) w_state_nxt = S_ACCUM;
            S_ACCUM: if (w_swap)     w_state_nxt = S_CLEAR;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) r_state <= S_CLEAR;
        else     r_state <= w_state_nxt;
    end

    // Clear after a swap touches only the new active bank; the final write lands in the old one.
    always_ff @(posedge clk) begin
        if (w_clear & (r_clr_both | ~r_his))   r_bank0[r_clr_cnt] <= '0;
        else if (r_wb_valid & ~r_wb_bank)      r_bank0[r_wb_addr] <= w_inc;
        if (w_clear & (r_clr_both | r_his))    r_bank1[r_clr_cnt] <= '0;
        else if (r_wb_valid & r_wb_bank)       r_bank1[r_wb_addr] <= w_inc;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_clr_cnt  <= '0;
            r_clr_both <= 1'b1;
            r_in_cnt   <= '0;
            r_pix      <= '0;
            r_acq      <= '0;
            r_his      <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_bank  <= 1'b0;
            r_wb_data  <= '0;
            r_sat_int  <= 1'b0;
            r_sat_flag <= 1'b0;
            r_drop     <= 1'b0;
            r_acq_done <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (w_clear) begin
                r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + AW'(1);
                if (w_clr_last) r_clr_both <= 1'b0;
            end
            r_wb_valid <= w_accept;
            if (w_accept) begin
                r_wb_addr <= w_acc_addr;
                r_wb_bank <= r_his;
                r_wb_data <= w_fwd ? w_inc : w_rd_acc;
                if (w_last_in) begin
                    r_in_cnt <= '0;
                    if (w_last_pix) begin
                        r_pix <= '0;
                        r_acq <= (r_acq == ACQ_LAST) ? '0 : r_acq + QW'(1);
                    end else begin
                        r_pix <= r_pix + PW'(1);
                    end
                end else begin
                    r_in_cnt <= r_in_cnt + IW'(1);
                end
            end
            if (wr_en & w_clear) r_drop <= 1'b1;
            r_acq_done <= w_swap;
            if (w_swap) r_his <= ~r_his;
            // A saturating write that trails the swap belongs to the finished bank.
            if (w_swap) begin
                r_sat_flag <= r_sat_int | w_wb_sat;
                r_sat_int  <= 1'b0;
            end else if (w_wb_sat) begin
                if (r_wb_bank == r_his) r_sat_int  <= 1'b1;
                else                    r_sat_flag <= 1'b1;
            end
            r_rd_data <= r_clr_both ? '0 : (r_his ? r_bank0[rd_addr] : r_bank1[rd_addr]);
        end
    end

    assign ready     = (r_state == S_ACCUM);
    assign rd_data   = r_rd_data;
    assign pixel_idx = r_pix;
    assign his_num   = r_his;
    assign acq_done  = r_acq_done;
    assign sat_flag  = r_sat_flag;
    assign drop_flag = r_drop;
endmodule

// File: tb/tb_dtof_hist_builder_pp.sv
// tb/tb_dtof_hist_builder_pp.sv - directed table-driven bench for dtof_hist_builder_pp
module tb_dtof_hist_builder_pp;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       res, wr_en, ready, his_num, acq_done, sat_flag, drop_flag;
    logic [3:0] addr;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [0:0] pixel_idx;

    logic       res_s, wr_en_s, ready_s, his_num_s, acq_done_s, sat_flag_s, drop_flag_s;
    logic [3:0] addr_s;
    logic [4:0] rd_addr_s;
    logic [1:0] rd_data_s;
    logic [0:0] pixel_idx_s;

    dtof_hist_builder_pp dut (
        .clk(clk), .res(res), .wr_en(wr_en), .addr(addr), .ready(ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .pixel_idx(pixel_idx), .his_num(his_num),
        .acq_done(acq_done), .sat_flag(sat_flag), .drop_flag(drop_flag)
    );

    dtof_hist_builder_pp #(.NB(4), .BIN_W(2), .DATA_NUM(8), .PIXEL_NUM(2), .ACQ_NUM(2)) dut_s (
        .clk(clk), .res(res_s), .wr_en(wr_en_s), .addr(addr_s), .ready(ready_s),
        .rd_addr(rd_addr_s), .rd_data(rd_data_s), .pixel_idx(pixel_idx_s), .his_num(his_num_s),
        .acq_done(acq_done_s), .sat_flag(sat_flag_s), .drop_flag(drop_flag_s)
    );

    typedef struct {
        logic       we;
        logic [3:0] a;
        logic       pix;
        logic       done;
        logic       rdy;
        logic       his;
    } vec_t;
    vec_t tbl [14];

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic ev_m(input logic [3:0] a);
        wr_en = 1'b1;
        addr  = a;
        @(negedge clk);
    endtask

    task automatic rd_m(input logic [4:0] a, input int exp, input string nm);
        rd_addr = a;
        @(negedge clk);
        chk(nm, rd_data, exp);
    endtask

    task automatic wait_ready_m(input logic hold, input int exp, input string nm);
        int n = 0;
        wr_en = hold;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        wr_en = 1'b0;
        chk(nm, n, exp);
    endtask

    task automatic ev_s(input logic [3:0] a);
        wr_en_s = 1'b1;
        addr_s  = a;
        @(negedge clk);
    endtask

    task automatic rd_s(input logic [4:0] a, input int exp, input string nm);
        rd_addr_s = a;
        @(negedge clk);
        chk(nm, rd_data_s, exp);
    endtask

    task automatic wait_ready_s(input int exp, input string nm);
        int n = 0;
        while (!ready_s && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(nm, n, exp);
    endtask

    initial begin
        logic [3:0] a4;
        res = 1'b1; wr_en = 1'b0; addr = '0; rd_addr = '0;
        res_s = 1'b1; wr_en_s = 1'b0; addr_s = '0; rd_addr_s = '0;

        // we, addr, expected pixel_idx / acq_done / ready / his_num after the edge
        tbl[0]  = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_pixel_idx", pixel_idx, 0);
        chk("rst_his_num", his_num, 0);
        chk("rst_acq_done", acq_done, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_drop_flag", drop_flag, 0);
        res = 1'b0; res_s = 1'b0;
        wait_ready_m(1'b0, 32, "clear_len_reset");
        chk("his_after_reset", his_num, 0);
        for (int a = 0; a < 32; a++) rd_m(5'(a), 0, "rd_zero_after_reset");

        for (int i = 0; i < 14; i++) begin
            wr_en = tbl[i].we;
            addr  = tbl[i].a;
            @(negedge clk);
            chk("tbl_pixel_idx", pixel_idx, tbl[i].pix);
            chk("tbl_acq_done", acq_done, tbl[i].done);
            chk("tbl_ready", ready, tbl[i].rdy);
            chk("tbl_his_num", his_num, tbl[i].his);
            if (acq_done) n_done++;
        end
        chk("acq_done_pulses", n_done, 1);
        wr_en = 1'b0;
        rd_m(5'd2, 6, "rd_during_clear");
        wait_ready_m(1'b0, 31, "clear_len_swap");
        rd_m(5'd2, 6, "hist_a_p0_b2");
        rd_m(5'd18, 6, "hist_a_p1_b2");
        rd_m(5'd5, 0, "hist_a_p0_b5");
        rd_m(5'd31, 0, "hist_a_p1_b15");
        chk("drop_clean", drop_flag, 0);
        chk("sat_clean", sat_flag, 0);

        for (int i = 0; i < 6; i++) ev_m(4'd5);
        for (int i = 0; i < 6; i++) ev_m(4'd9);
        chk("hist_b_acq_done", acq_done, 1);
        chk("hist_b_his_num", his_num, 0);
        wait_ready_m(1'b1, 32, "clear_len_held_wr");
        chk("drop_set", drop_flag, 1);
        chk("drop_pixel_idx", pixel_idx, 0);
        chk("drop_his_num", his_num, 0);
        rd_m(5'd5, 3, "hist_b_p0_b5");
        rd_m(5'd21, 3, "hist_b_p1_b5");
        rd_m(5'd9, 3, "hist_b_p0_b9");
        rd_m(5'd25, 3, "hist_b_p1_b9");
        rd_m(5'd2, 0, "hist_b_p0_b2");

        for (int i = 0; i < 3; i++) ev_m(4'd1);
        chk("count_from_zero", pixel_idx, 1);
        ev_m(4'd1);
        ev_m(4'd1);
        wr_en = 1'b0;
        res = 1'b1;
        #1;
        chk("midres_ready", ready, 0);
        chk("midres_his_num", his_num, 0);
        chk("midres_pixel_idx", pixel_idx, 0);
        chk("midres_drop", drop_flag, 0);
        @(negedge clk);
        res = 1'b0;
        wait_ready_m(1'b0, 32, "clear_len_midres");
        for (int a = 0; a < 32; a++) rd_m(5'(a), 0, "rd_zero_bank1_midres");
        for (int i = 0; i < 12; i++) ev_m(4'd3);
        wr_en = 1'b0;
        chk("hist_d_acq_done", acq_done, 1);
        chk("hist_d_his_num", his_num, 1);
        rd_m(5'd3, 6, "hist_d_p0_b3");
        rd_m(5'd19, 6, "hist_d_p1_b3");
        rd_m(5'd1, 0, "hist_d_p0_b1");
        rd_m(5'd17, 0, "hist_d_p1_b1");

        for (int i = 0; i < 32; i++) begin
            a4 = (i < 8) ? 4'd7 : (i < 24) ? 4'(i - 8) : 4'(i - 16);
            ev_s(a4);
        end
        wr_en_s = 1'b0;
        chk("sat_acq_done", acq_done_s, 1);
        chk("sat_his_num", his_num_s, 1);
        chk("sat_flag_set", sat_flag_s, 1);
        rd_s(5'd7, 3, "sat_p0_b7");
        rd_s(5'd16, 1, "sat_p1_b0");
        rd_s(5'd8, 1, "sat_p0_b8");
        wait_ready_s(29, "sat_clear_len");
        for (int i = 0; i < 32; i++) begin
            if (i == 16) chk("sat_flag_sticky", sat_flag_s, 1);
            a4 = 4'(i);
            ev_s(a4);
        end
        wr_en_s = 1'b0;
        chk("sat2_acq_done", acq_done_s, 1);
        chk("sat2_his_num", his_num_s, 0);
        chk("sat_flag_cleared", sat_flag_s, 0);
        rd_s(5'd0, 2, "sat2_p0_b0");
        rd_s(5'd24, 2, "sat2_p1_b8");
        chk("sat_no_drop", drop_flag_s, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dtof_hist_builder_pp.md
Name: dtof_hist_builder_pp

Overview:
- Parametrised successor to the single-histogram dToF bin counter.
- Accumulates TDC timestamps (bin addresses) into per-pixel histograms held in two ping-pong RAM banks.
- Nested counters track photon events per pixel, pixels per frame and acquisitions per histogram.
- When a histogram is complete, the banks swap: the finished bank is handed to the downstream peak-detect/readout logic while a freshly cleared bank accumulates the next histogram.

Parameters:
- NB, 4, bin address width; bins per pixel = 2^NB.
- BIN_W, 8, bin count width; counts saturate at 2^BIN_W-1.
- DATA_NUM, 3, photon events per pixel slot before advancing to the next pixel.
- PIXEL_NUM, 2, pixels per bank; each pixel owns 2^NB bins.
- ACQ_NUM, 2, full pixel sweeps per histogram before the bank swap.
- PW, 1, pixel index width, equal to max(1, clog2(PIXEL_NUM)).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- res  in  1  asynchronous, active-high reset.
- wr_en  in  1  photon event valid, one event per cycle.
- addr  in  NB  bin index of the event.
- ready  out  1  high while accumulating; events are accepted only when ready=1.
- rd_addr  in  PW+NB  readout address {pixel, bin} into the finished (inactive) bank.
- rd_data  out  BIN_W  count at rd_addr, 1-cycle latency.
- pixel_idx  out  PW  current pixel being accumulated.
- his_num  out  1  bank currently accumulating; the readout bank is ~his_num.
- acq_done  out  1  one-cycle pulse when a histogram completes and the banks swap.
- sat_flag  out  1  sticky: any bin of the finished bank saturated; cleared on the next swap.
- drop_flag  out  1  sticky: wr_en arrived while ready=0; cleared by res only.

Behaviour:
- Reset values (res=1, asynchronous): ready=0, rd_data=0, pixel_idx=0, his_num=0, acq_done=0, sat_flag=0, drop_flag=0.
- On reset, all internal counters go to 0 and the state goes to CLEAR.
- States: CLEAR and ACCUM.
- CLEAR:
  - A clear counter sweeps PIXEL_NUM*2^NB addresses, one per cycle, writing 0.
  - The clear entered from reset writes both banks.
  - The clear entered from a swap writes only the new active bank.
  - After the last address, go to ACCUM; ready rises the next cycle.
  - CLEAR takes exactly PIXEL_NUM*2^NB cycles.
- ACCUM, per accepted event (wr_en & ready):
  - Read-modify-write at {pixel_idx, addr} in bank his_num.
  - Stage 1 reads the bin; stage 2 writes count+1, saturating at all-ones.
  - A write that saturates sets an internal saturation bit.
- Hazard forwarding:
  - An event to the same {pixel, bin} as the event in stage 2 uses the forwarded stage-2 result, not the stale RAM value.
  - Back-to-back hits on one bin must count every event.
- Event counting:
  - input_count increments per accepted event.
  - When it reaches DATA_NUM-1 and another event is accepted, input_count goes to 0 and pixel_idx increments.
  - pixel_idx wraps from PIXEL_NUM-1 to 0; on that wrap, acq_count increments.
- Histogram completion: when acq_count would reach ACQ_NUM on that wrap, in the same cycle:
  - acq_count goes to 0.
  - acq_done pulses for 1 cycle.
  - his_num toggles.
  - sat_flag loads the internal saturation bit, and the internal bit clears.
  - state goes to CLEAR and ready drops the next cycle.
- The final event of a histogram is still written to the old bank: the stage-2 write uses its latched bank bit, not his_num.
- Readout:
  - rd_data is registered from bank ~his_num; rd_addr is sampled every cycle.
  - rd_data during CLEAR reflects the finished bank, which is untouched by the clear.
  - Immediately after reset, reads return 0.
- Events while ready=0 are discarded, set drop_flag, and do not advance any counter.
- An event accepted in the cycle ready falls (the swap cycle) is the last event of the old histogram; no event is lost or double-counted.
- A res assertion mid-RMW aborts the pending write; the bank contents are then cleared by the CLEAR sweep.
- rd_addr values with pixel field >= PIXEL_NUM return undefined data; the bench must not check them.

Test Plan (default parameters; CLEAR takes 32 cycles):
- Reset then idle: ready=0 for 32 cycles after res falls, then 1; his_num=0; rd_data=0 at every rd_addr.
- Six events with addr=5 back-to-back (3 per pixel) -> after the second sweep starts, pixel_idx cycles 0,1; bins {0,5} and {1,5} both = 3 in bank 0; drop_flag=0.
- 12 events, addr=2 throughout -> acq_done pulses exactly once, coincident with the 12th accepted event; his_num=1; reading rd_addr {0,2} returns 6 and {1,2} returns 6; ready low for 32 cycles, then high.
- Saturation, BIN_W=2 with DATA_NUM=8: 8 back-to-back events to addr=7 -> bin = 3; after completing the histogram, sat_flag=1; sat_flag=0 after the next swap if no saturation occurred.
- wr_en held during CLEAR after the swap -> drop_flag=1; counters unchanged; the next histogram counts start from 0.
- res pulsed mid-histogram after 5 events -> ready=0, his_num=0, pixel_idx=0; after the 32-cycle clear, all bins read 0 from both banks.
